// File: rtl/simd_add_scheduler.sv
// simd_add_scheduler: round-robin sharing of one free-running pipelined SIMD adder among NREQ requesters.
// Latency: a request accepted in cycle t reaches the result FIFO head in cycle t+LAT+1 (FIFO empty).
// Backpressure: issue only while fifo_count + inflight < DEPTH; req_ready never looks at rsp_ready.
// Optional build macro SIMD_SCHED_STATS_EN adds stat_issue / stat_stall saturating counters.

// Generic result FIFO: ring buffer with an occupancy count, head data zeroed when empty.
// Latency: pushed entry visible at the head the cycle after the push.
// Backpressure: none internally; the caller guarantees no push while full (asserted).
module simd_sched_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic             head_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic [CW-1:0]    count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_pop;

    // Pointer increment that wraps at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    assign do_pop   = pop_rdy && (count != '0);
    assign head_vld = (count != '0);
    assign head_dat = head_vld ? mem[rd_ptr] : '0;

    // Storage write; contents need no reset because the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push_vld) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= wrap_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= wrap_inc(rd_ptr);
            end
            case ({push_vld, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // The credit scheme upstream must make overflow impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_vld && (count == CW'(DEPTH))));

endmodule

module simd_add_scheduler #(
    parameter int NREQ  = 4,
    parameter int N     = 4,
    parameter int W     = 10,
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*N*W-1:0]      req_a,
    input  logic [NREQ*N*W-1:0]      req_b,
    output logic [N*W-1:0]           add_a,
    output logic [N*W-1:0]           add_b,
    input  logic [N*W-1:0]           add_sum,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [N*W-1:0]           rsp_sum
`ifdef SIMD_SCHED_STATS_EN
    ,
    output logic [NREQ*16-1:0]       stat_issue,
    output logic [15:0]              stat_stall
`endif
);
    localparam int IDW = $clog2(NREQ);
    localparam int VW  = N * W;
    localparam int FCW = $clog2(DEPTH + 1);
    localparam int CW  = $clog2(DEPTH + LAT + 1);

    // Round-robin state: last granted requester.
    logic [IDW-1:0] ptr;

    // Arbitration result for the current cycle.
    logic           issue_ok;
    logic           grant_any;
    logic [IDW-1:0] grant_id;

    // Tag pipe tracking what the adder currently holds.
    logic [LAT-1:0] tag_vld;
    logic [IDW-1:0] tag_id [LAT];
    logic [CW-1:0]  inflight;

    // Result FIFO interface.
    logic [FCW-1:0]    fifo_count;
    logic [IDW+VW-1:0] head_dat;

    // Requester index ptr+k modulo NREQ.
    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
        int t;
        t = (int'(base) + k) % NREQ;
        return IDW'(t);
    endfunction

    // Count valid tag-pipe stages: results already committed to the adder.
    always_comb begin
        inflight = '0;
        for (int s = 0; s < LAT; s++) begin
            inflight = inflight + CW'(tag_vld[s]);
        end
    end

    // Credit check uses registered state only, so a pop frees credit the next cycle.
    assign issue_ok = ((CW'(fifo_count) + inflight) < CW'(DEPTH));

    // Round-robin search starting after the last winner; nothing is granted during reset.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        if (issue_ok && !rst) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (!grant_any && req_valid[rr_idx(ptr, k)]) begin
                    grant_any = 1'b1;
                    grant_id  = rr_idx(ptr, k);
                end
            end
        end
    end

    // One-hot ready for the winner and operand steering to the adder.
    always_comb begin
        req_ready = '0;
        add_a     = '0;
        add_b     = '0;
        if (grant_any) begin
            req_ready[grant_id] = 1'b1;
            add_a = req_a[int'(grant_id)*VW +: VW];
            add_b = req_b[int'(grant_id)*VW +: VW];
        end
    end

    // Pointer moves to the winner; reset makes requester 0 first in line.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= IDW'(NREQ - 1);
        end else if (grant_any) begin
            ptr <= grant_id;
        end
    end

    // Tag pipe shifts every cycle alongside the free-running adder; reset drops in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld <= '0;
            for (int s = 0; s < LAT; s++) begin
                tag_id[s] <= '0;
            end
        end else begin
            tag_vld[0] <= grant_any;
            tag_id[0]  <= grant_id;
            for (int s = 1; s < LAT; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_id[s]  <= tag_id[s-1];
            end
        end
    end

    // Capture the adder output with its tag when the last stage is valid.
    simd_sched_fifo #(
        .WIDTH (IDW + VW),
        .DEPTH (DEPTH),
        .CW    (FCW)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (tag_vld[LAT-1]),
        .push_dat ({tag_id[LAT-1], add_sum}),
        .pop_rdy  (rsp_ready),
        .head_vld (rsp_valid),
        .head_dat (head_dat),
        .count    (fifo_count)
    );

    assign {rsp_id, rsp_sum} = head_dat;

`ifdef SIMD_SCHED_STATS_EN
    // Saturating per-requester issue counters and a credit-stall cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issue <= '0;
            stat_stall <= '0;
        end else begin
            if (grant_any && (stat_issue[int'(grant_id)*16 +: 16] != 16'hFFFF)) begin
                stat_issue[int'(grant_id)*16 +: 16] <= stat_issue[int'(grant_id)*16 +: 16] + 16'd1;
            end
            if ((|req_valid) && !issue_ok && (stat_stall != 16'hFFFF)) begin
                stat_stall <= stat_stall + 16'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
